// File: rtl/ssbiq_pkg.sv
// ssbiq_pkg: shared definitions for the PSK H-bridge modulator.
//   state_t          - controller states (OFF, RAMP, RUN, DOWN)
//   *_DEF            - default parameter values used by psk_bridge_modulator
package ssbiq_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  localparam int PHASE_W_DEF   = 27;
  localparam int FREQ_W_DEF    = 18;
  localparam int PSK_BITS_DEF  = 2;
  localparam int SYM_LEN_DEF   = 62500;
  localparam int RAMP_STEP_DEF = 64;

endpackage

// File: rtl/ssbiq_amp_slew.sv
// ssbiq_amp_slew: combinational slew limiter.
//   target  - value to move toward
//   step    - maximum change per evaluation
//   current - present value
//   slewed  - current moved toward target by at most step, never past it
// Differences are taken in the direction that cannot underflow, and the
// step is only added/subtracted when it stays strictly short of the target,
// so the result never wraps at W bits.
module ssbiq_amp_slew #(
  parameter int W = 26
) (
  input  logic [W-1:0] target,
  input  logic [W-1:0] step,
  input  logic [W-1:0] current,
  output logic [W-1:0] slewed
);

  always_comb begin
    slewed = current;
    if (current < target) begin
      if ((target - current) > step) slewed = current + step;
      else                            slewed = target;
    end else if (current > target) begin
      if ((current - target) > step) slewed = current - step;
      else                            slewed = target;
    end
  end

endmodule

// File: rtl/psk_bridge_modulator.sv
// psk_bridge_modulator: PWM H-bridge carrier generator with M-PSK symbol
// phase steps and slewed amplitude ramp-up / graceful ramp-down.
//   clk, rst           - clock, asynchronous active-high reset
//   freq               - phase increment per clock (carrier tuning word)
//   amplitude          - target pulse width within each half-cycle
//   psk_en             - enable symbol phase modulation
//   sym_data/valid     - next symbol from the source (held until accepted)
//   sym_ready          - symbol boundary; symbol taken when sym_valid is high
//   stdby              - request ramp-down and shutdown
//   DRV0 / DRV1        - registered bridge drives, positive / negative half
//   busy               - any state other than OFF
//   underrun           - symbol boundary with no symbol available
module psk_bridge_modulator
  import ssbiq_pkg::*;
#(
  parameter int PHASE_W   = PHASE_W_DEF,
  parameter int FREQ_W    = FREQ_W_DEF,
  parameter int PSK_BITS  = PSK_BITS_DEF,
  parameter int SYM_LEN   = SYM_LEN_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FREQ_W-1:0]    freq,
  input  logic [PHASE_W-2:0]   amplitude,
  input  logic                 psk_en,
  input  logic [PSK_BITS-1:0]  sym_data,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic                 stdby,
  output logic                 DRV0,
  output logic                 DRV1,
  output logic                 busy,
  output logic                 underrun
);

  localparam int CNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [CNT_W-1:0]   SYM_LAST = CNT_W'(SYM_LEN - 1);
  localparam logic [PHASE_W-2:0] STEP     = (PHASE_W-1)'(RAMP_STEP);

  state_t                state, state_next;
  logic [PHASE_W-1:0]    acc, ph, freq_ext, sym_phase;
  logic [PHASE_W-2:0]    amp_cur, amp_target, amp_slewed, u;
  logic [PSK_BITS-1:0]   sym_reg;
  logic [CNT_W-1:0]      sym_cnt;
  logic                  half, boundary;

  assign freq_ext  = {{(PHASE_W-FREQ_W){1'b0}}, freq};
  assign sym_phase = {sym_reg, {(PHASE_W-PSK_BITS){1'b0}}};
  assign ph        = acc + sym_phase;
  assign half      = ph[PHASE_W-1];
  assign u         = ph[PHASE_W-2:0];

  assign busy      = (state != ST_OFF);
  assign boundary  = psk_en & busy & (sym_cnt == SYM_LAST);
  assign sym_ready = boundary;
  assign underrun  = boundary & ~sym_valid;

  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:  if (!stdby) state_next = ST_RAMP;
      ST_RAMP: begin
        if (stdby)                        state_next = ST_DOWN;
        else if (amp_cur == amplitude)    state_next = ST_RUN;
      end
      ST_RUN:  if (stdby) state_next = ST_DOWN;
      ST_DOWN: begin
        if (!stdby)                       state_next = ST_RAMP;
        else if (amp_cur == '0)           state_next = ST_OFF;
      end
      default: state_next = ST_OFF;
    endcase
  end

  // Target follows the state being entered so the ramp-down starts on the
  // same edge that enters DOWN.
  assign amp_target = (state_next == ST_DOWN) ? '0 : amplitude;

  ssbiq_amp_slew #(.W(PHASE_W-1)) u_slew (
    .target  (amp_target),
    .step    (STEP),
    .current (amp_cur),
    .slewed  (amp_slewed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_OFF;
      acc     <= '0;
      amp_cur <= '0;
      sym_reg <= '0;
      sym_cnt <= '0;
      DRV0    <= 1'b0;
      DRV1    <= 1'b0;
    end else begin
      state <= state_next;

      // Clearing on entry keeps acc/amp_cur at zero for the whole OFF stay.
      if (state_next == ST_OFF) begin
        acc     <= '0;
        amp_cur <= '0;
      end else begin
        acc     <= acc + freq_ext;
        amp_cur <= amp_slewed;
      end

      if (state_next == ST_OFF || !psk_en) begin
        sym_cnt <= '0;
        sym_reg <= '0;
      end else begin
        sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;
        if (boundary && sym_valid) sym_reg <= sym_data;
      end

      // half selects the leg, so the two drives are mutually exclusive.
      DRV0 <= busy & ~half & (u < amp_cur);
      DRV1 <= busy &  half & (u < amp_cur);
    end
  end

endmodule

// File: tb/tb_psk_bridge_modulator.sv
module tb_psk_bridge_modulator;
  import ssbiq_pkg::*;

  localparam int PW = 27;
  localparam int FW = 18;
  localparam int PB = 2;
  localparam int SL = 1000;
  localparam int RS = 1 << 20;

  logic          clk, rst, psk_en, sym_valid, stdby;
  logic          sym_ready, DRV0, DRV1, busy, underrun;
  logic [FW-1:0] freq;
  logic [PW-2:0] amplitude;
  logic [PB-1:0] sym_data;

  int n_chk  = 0;
  int n_pass = 0;

  psk_bridge_modulator #(
    .PHASE_W(PW), .FREQ_W(FW), .PSK_BITS(PB), .SYM_LEN(SL), .RAMP_STEP(RS)
  ) dut (
    .clk(clk), .rst(rst), .freq(freq), .amplitude(amplitude),
    .psk_en(psk_en), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .stdby(stdby), .DRV0(DRV0), .DRV1(DRV1),
    .busy(busy), .underrun(underrun)
  );

  initial begin
    clk = 1'b0;
    forever #8 clk = ~clk;
  end

  typedef struct {
    logic [FW-1:0] f;
    logic [PW-2:0] amp;
    int            exp0;
    int            exp1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Advance to 4 ns after the next rising edge; inputs are driven here.
  task automatic tick;
    @(posedge clk);
    #4;
  endtask

  initial begin
    int d0, d1, both, last, imin, imax, found;
    int first_ready, first_und, nready, nund, r1, r2;
    logic p0;

    // 2^16 tuning word: 2048-cycle period, acc stays a multiple of 2^16,
    // so drive-high counts per period are exactly ceil(amp / 2^16).
    vecs[0] = '{18'd65536,  26'd33554432, 512,  512};
    vecs[1] = '{18'd65536,  26'd16777216, 256,  256};
    vecs[2] = '{18'd65536,  26'd65537,    2,    2};
    vecs[3] = '{18'd65536,  26'd67108863, 1024, 1024};
    vecs[4] = '{18'd65536,  26'd0,        0,    0};
    vecs[5] = '{18'd131072, 26'd33554432, 512,  512};
    vecs[6] = '{18'd131072, 26'd12582912, 192,  192};
    vecs[7] = '{18'd65536,  26'd33554432, 512,  512};

    rst = 1'b1; stdby = 1'b1; freq = 18'd178176; amplitude = 26'd33554432;
    psk_en = 1'b0; sym_valid = 1'b0; sym_data = '0;
    repeat (3) tick;
    #1;
    chk("rst_drv0", 64'(DRV0), 64'd0);
    chk("rst_drv1", 64'(DRV1), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(sym_ready), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_acc", 64'(dut.acc), 64'd0);

    rst = 1'b0;
    repeat (3) tick;
    #1;
    chk("off_hold_stdby", 64'(busy), 64'd0);

    // Start-up ramp: 32 steps of 2^20 to reach 2^25, RUN on the 33rd edge.
    stdby = 1'b0;
    tick; #1;
    chk("leave_off_busy", 64'(busy), 64'd1);
    chk("leave_off_ramp", 64'(dut.state), 64'(ST_RAMP));
    repeat (31) tick;
    #1;
    chk("ramp_state_32", 64'(dut.state), 64'(ST_RAMP));
    chk("ramp_amp_32", 64'(dut.amp_cur), 64'd33554432);
    tick; #1;
    chk("ramp_run_33", 64'(dut.state), 64'(ST_RUN));

    // Period ~753.3 cycles, each drive ~188.3 cycles high per period.
    d0 = 0; d1 = 0; both = 0; last = -1; imin = 99999; imax = 0; p0 = DRV0;
    for (int i = 0; i < 3013; i++) begin
      tick; #1;
      if (DRV0 && DRV1) both++;
      if (DRV0) d0++;
      if (DRV1) d1++;
      if (DRV0 && !p0) begin
        if (last >= 0) begin
          if (i - last < imin) imin = i - last;
          if (i - last > imax) imax = i - last;
        end
        last = i;
      end
      p0 = DRV0;
    end
    chk_rng("period_min", imin, 752, 755);
    chk_rng("period_max", imax, 752, 755);
    chk_rng("duty_drv0", d0, 747, 759);
    chk_rng("duty_drv1", d1, 747, 759);
    chk("overlap_run", 64'(both), 64'd0);

    // Zero amplitude: 32 slew steps plus one register stage.
    amplitude = '0;
    repeat (33) tick;
    #1;
    chk("zero_amp_drv0", 64'(DRV0), 64'd0);
    chk("zero_amp_drv1", 64'(DRV1), 64'd0);
    d0 = 0;
    for (int i = 0; i < 800; i++) begin
      tick; #1;
      if (DRV0 || DRV1) d0++;
    end
    chk("zero_amp_quiet", 64'(d0), 64'd0);
    chk("zero_amp_busy", 64'(busy), 64'd1);
    chk("zero_amp_run", 64'(dut.state), 64'(ST_RUN));

    amplitude = 26'd33554432;
    repeat (40) tick;

    // Graceful standby from amp_cur = 2^25.
    stdby = 1'b1;
    tick; #1;
    chk("down_enter", 64'(dut.state), 64'(ST_DOWN));
    chk("down_first_step", 64'(dut.amp_cur), 64'd32505856);
    chk("down_busy", 64'(busy), 64'd1);
    repeat (31) tick;
    #1;
    chk("down_state_32", 64'(dut.state), 64'(ST_DOWN));
    chk("down_amp_32", 64'(dut.amp_cur), 64'd0);
    tick; #1;
    chk("off_state", 64'(dut.state), 64'(ST_OFF));
    chk("off_busy", 64'(busy), 64'd0);
    chk("off_drv0", 64'(DRV0), 64'd0);
    chk("off_drv1", 64'(DRV1), 64'd0);
    chk("off_acc", 64'(dut.acc), 64'd0);

    freq = 18'd65536;
    repeat (3) tick;
    stdby = 1'b0;
    tick; #1;
    chk("restart_ramp", 64'(dut.state), 64'(ST_RAMP));
    repeat (10) tick;
    stdby = 1'b1;
    tick; #1;
    chk("ramp_to_down", 64'(dut.state), 64'(ST_DOWN));
    repeat (3) tick;
    stdby = 1'b0;
    tick; #1;
    chk("down_to_ramp", 64'(dut.state), 64'(ST_RAMP));
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      tick; #1;
      if (dut.state == ST_RUN) found = 1;
    end
    chk("reramp_run", 64'(found), 64'd1);

    // Table: drive-high counts over one 2048-cycle window after settling.
    for (int v = 0; v < 8; v++) begin
      freq = vecs[v].f;
      amplitude = vecs[v].amp;
      repeat (100) tick;
      d0 = 0; d1 = 0; both = 0;
      for (int i = 0; i < 2048; i++) begin
        tick; #1;
        if (DRV0) d0++;
        if (DRV1) d1++;
        if (DRV0 && DRV1) both++;
      end
      chk($sformatf("vec%0d_drv0", v), 64'(d0), 64'(vecs[v].exp0));
      chk($sformatf("vec%0d_drv1", v), 64'(d1), 64'(vecs[v].exp1));
      chk($sformatf("vec%0d_overlap", v), 64'(both), 64'd0);
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'd1);
    end

    // Symbol phase step, synchronised to a DRV0 rising edge.
    found = 0; p0 = DRV0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      tick; #1;
      if (DRV0 && !p0) found = 1;
      p0 = DRV0;
    end
    chk("sync_rise", 64'(found), 64'd1);
    psk_en = 1'b1; sym_data = 2'd1; sym_valid = 1'b1;
    #1;
    first_ready = -1; first_und = -1; nready = 0; nund = 0; r1 = -1; r2 = -1;
    both = 0; p0 = 1'b1;
    for (int i = 0; i < 4200; i++) begin
      if (i > 0) begin
        tick;
        if (first_ready == i - 1) begin
          sym_valid = 1'b0;
          sym_data = 2'd3;
        end
        #1;
      end
      if (sym_ready) begin
        nready++;
        if (first_ready < 0) first_ready = i;
      end
      if (underrun) begin
        nund++;
        if (first_und < 0) first_und = i;
      end
      if (DRV0 && DRV1) both++;
      if (DRV0 && !p0) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      p0 = DRV0;
    end
    chk("first_ready_cycle", 64'(first_ready), 64'd999);
    chk("ready_count", 64'(nready), 64'd4);
    chk("phase_step_rise", 64'(r1), 64'd1536);
    chk("post_step_rise", 64'(r2), 64'd3584);
    chk("first_underrun", 64'(first_und), 64'd1999);
    chk("underrun_count", 64'(nund), 64'd3);
    chk("underrun_hold_sym", 64'(dut.sym_reg), 64'd1);
    chk("overlap_psk", 64'(both), 64'd0);

    psk_en = 1'b0;
    tick; #1;
    chk("psk_off_sym", 64'(dut.sym_reg), 64'd0);
    nready = 0; nund = 0;
    for (int i = 0; i < 1100; i++) begin
      tick; #1;
      if (sym_ready) nready++;
      if (underrun) nund++;
    end
    chk("psk_off_ready", 64'(nready), 64'd0);
    chk("psk_off_underrun", 64'(nund), 64'd0);

    // Asynchronous reset while a drive is high, between clock edges.
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      tick; #1;
      if (DRV0 || DRV1) found = 1;
    end
    chk("pre_reset_drive", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_drv0", 64'(DRV0), 64'd0);
    chk("async_drv1", 64'(DRV1), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_state", 64'(dut.state), 64'(ST_OFF));
    chk("async_acc", 64'(dut.acc), 64'd0);
    chk("async_amp", 64'(dut.amp_cur), 64'd0);
    tick;
    rst = 1'b0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
